// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN0,
    ARB_OWN1
  } arb_state_e;

  localparam int PORT_CORE = 0;
  localparam int PORT_DMA  = 1;

  // Counter width able to hold 0..max_lock without wrapping.
  function automatic int lock_cnt_w(input int max_lock);
    return (max_lock < 1) ? 1 : $clog2(max_lock + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way combinational picker: a lone requester always wins; on contention,
// the port that is not named by ptr (the last winner) wins.
module dmem_arb_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory with locked RMW sequences.
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wd,
  input  logic              p0_lock,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wd,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int LCW = lock_cnt_w(MAX_LOCK);

  arb_state_e        state_q, state_d;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d, lock_cnt_inc;
  logic              p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic [1:0]        req, pick_gnt, gnt;
  logic              pick_ptr, acc_lock;

`ifdef DMEM_ARB_RR_EN
  logic ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = 1'b1;
`endif

  assign req = {p1_req, p0_req};

  dmem_arb_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .gnt (pick_gnt)
  );

  // Grants are suppressed while in reset so nothing reaches memory.
  always_comb begin
    gnt = 2'b00;
    if (rst) begin
      case (state_q)
        ARB_IDLE: gnt = pick_gnt;
        ARB_OWN0: gnt[PORT_CORE] = p0_req;
        ARB_OWN1: gnt[PORT_DMA]  = p1_req;
        default:  gnt = 2'b00;
      endcase
    end
  end

  assign p0_gnt = gnt[PORT_CORE];
  assign p1_gnt = gnt[PORT_DMA];

  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (gnt[PORT_CORE]) begin
      mem_we = p0_we;
      mem_a  = p0_addr;
      mem_wd = p0_wd;
    end else if (gnt[PORT_DMA]) begin
      mem_we = p1_we;
      mem_a  = p1_addr;
      mem_wd = p1_wd;
    end
  end

  assign acc_lock     = (gnt[PORT_CORE] & p0_lock) | (gnt[PORT_DMA] & p1_lock);
  assign lock_cnt_inc = lock_cnt_q + LCW'(1);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
`ifdef DMEM_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|gnt) begin
`ifdef DMEM_ARB_RR_EN
          ptr_d = gnt[PORT_DMA];
`endif
          // The entry beat already counts; MAX_LOCK of 1 never holds ownership.
          if (acc_lock && (MAX_LOCK > 1)) begin
            state_d    = gnt[PORT_DMA] ? ARB_OWN1 : ARB_OWN0;
            lock_cnt_d = LCW'(1);
          end
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        if (!(|gnt) || !acc_lock || (lock_cnt_inc >= LCW'(MAX_LOCK))) begin
          state_d    = ARB_IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_inc;
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    p0_rvalid_d = gnt[PORT_CORE] & ~p0_we;
    p1_rvalid_d = gnt[PORT_DMA] & ~p1_we;
    p0_rdata_d  = p0_rvalid_d ? mem_rd : p0_rdata_q;
    p1_rdata_d  = p1_rvalid_d ? mem_rd : p1_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      lock_cnt_q  <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
      ptr_q       <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
`ifdef DMEM_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector bench for dmem_arbiter with a small behavioural memory.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
  logic [31:0] p0_addr, p0_wd, p0_rdata;
  logic        p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
  logic [31:0] p1_addr, p1_wd, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:63];
  logic        ld_en;
  logic [5:0]  ld_idx;
  logic [31:0] ld_val;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wd(p0_wd), .p0_lock(p0_lock),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wd(p1_wd), .p1_lock(p1_lock),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  typedef struct {
    logic        rst;
    logic        r0, w0, l0;
    logic [31:0] a0, d0;
    logic        r1, w1, l1;
    logic [31:0] a1, d1;
    logic [1:0]  gnt;
    logic        mwe;
    logic [31:0] ma;
    logic [1:0]  rv;
    logic [31:0] rd0, rd1;
  } vec_t;

  function automatic vec_t mk(
    input logic rs,
    input logic r0, input logic w0, input logic l0, input logic [31:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic l1, input logic [31:0] a1, input logic [31:0] d1,
    input logic [1:0] g, input logic mwe, input logic [31:0] ma,
    input logic [1:0] rv, input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.rst = rs;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.gnt = g; v.mwe = mwe; v.ma = ma; v.rv = rv; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  localparam logic [31:0] A = 32'hA5A5_A5A5;  // word at 0x20
  localparam logic [31:0] D = 32'hDEAD_BEEF;  // word at 0x40
  localparam logic [31:0] O = 32'h1111_1111;  // word at 0x10 before the RMW

  vec_t v [0:31];
  int   nv;
  int   p1_beats;
  bit   got0;

  initial begin
    rst = 1'b0;
    {p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock} = '0;
    {p0_addr, p0_wd, p1_addr, p1_wd} = '0;
    ld_en = 1'b0; ld_idx = '0; ld_val = '0;

    // Preload memory while held in reset.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_en  = 1'b1;
      ld_idx = (i == 0) ? 6'd4 : (i == 1) ? 6'd8 : (i == 2) ? 6'd16 : 6'd12;
      ld_val = (i == 0) ? O : (i == 1) ? A : (i == 2) ? D : 32'h0;
    end
    @(negedge clk);
    ld_en = 1'b0;

    nv = 0;
    // reset with both requesting, then port 0 wins first, then p1 read latency
    v[nv++] = mk(0, 1,0,0,32'h20,0, 1,0,0,32'h40,0, 2'b00,0,32'h00, 2'b00, 0, 0);
    v[nv++] = mk(1, 1,0,0,32'h20,0, 1,0,0,32'h40,0, 2'b01,0,32'h20, 2'b00, 0, 0);
    v[nv++] = mk(1, 0,0,0,32'h00,0, 1,0,0,32'h40,0, 2'b10,0,32'h40, 2'b01, A, 0);
    v[nv++] = mk(1, 0,0,0,32'h00,0, 0,0,0,32'h00,0, 2'b00,0,32'h00, 2'b10, A, D);
    // contention, no lock
    v[nv++] = mk(1, 1,0,0,32'h10,0, 1,0,0,32'h40,0, 2'b01,0,32'h10, 2'b00, A, D);
    v[nv++] = mk(1, 1,0,0,32'h10,0, 1,0,0,32'h40,0, RR ? 2'b10 : 2'b01,0, RR ? 32'h40 : 32'h10, 2'b01, O, D);
    v[nv++] = mk(1, 1,0,0,32'h10,0, 1,0,0,32'h40,0, 2'b01,0,32'h10, RR ? 2'b10 : 2'b01, O, D);
    v[nv++] = mk(1, 1,0,0,32'h10,0, 1,0,0,32'h40,0, RR ? 2'b10 : 2'b01,0, RR ? 32'h40 : 32'h10, 2'b01, O, D);
    v[nv++] = mk(1, 0,0,0,32'h00,0, 0,0,0,32'h00,0, 2'b00,0,32'h00, RR ? 2'b10 : 2'b01, O, D);
    // locked read-modify-write by p0 while p1 waits
    v[nv++] = mk(1, 1,0,1,32'h10,0, 1,0,0,32'h40,0, 2'b01,0,32'h10, 2'b00, O, D);
    v[nv++] = mk(1, 1,1,0,32'h10,5, 1,0,0,32'h40,0, 2'b01,1,32'h10, 2'b01, O, D);
    v[nv++] = mk(1, 0,0,0,32'h00,0, 1,0,0,32'h10,0, 2'b10,0,32'h10, 2'b00, O, D);
    v[nv++] = mk(1, 0,0,0,32'h00,0, 0,0,0,32'h00,0, 2'b00,0,32'h00, 2'b10, O, 5);
    // forced release after MAX_LOCK beats
    v[nv++] = mk(1, 1,0,1,32'h20,0, 1,0,0,32'h40,0, 2'b01,0,32'h20, 2'b00, O, 5);
    v[nv++] = mk(1, 1,0,1,32'h20,0, 1,0,0,32'h40,0, 2'b01,0,32'h20, 2'b01, A, 5);
    v[nv++] = mk(1, 1,0,1,32'h20,0, 1,0,0,32'h40,0, 2'b01,0,32'h20, 2'b01, A, 5);
    v[nv++] = mk(1, 1,0,1,32'h20,0, 1,0,0,32'h40,0, 2'b01,0,32'h20, 2'b01, A, 5);
    v[nv++] = mk(1, 1,0,1,32'h20,0, 1,0,0,32'h40,0, RR ? 2'b10 : 2'b01,0, RR ? 32'h40 : 32'h20, 2'b01, A, 5);
    v[nv++] = mk(1, 0,0,0,32'h00,0, 1,0,0,32'h40,0, RR ? 2'b10 : 2'b00,0, RR ? 32'h40 : 32'h00,
                 RR ? 2'b10 : 2'b01, A, RR ? D : 32'd5);
    v[nv++] = mk(1, 0,0,0,32'h00,0, 1,0,0,32'h40,0, 2'b10,0,32'h40, RR ? 2'b10 : 2'b00, A, RR ? D : 32'd5);
    v[nv++] = mk(1, 0,0,0,32'h00,0, 0,0,0,32'h00,0, 2'b00,0,32'h00, 2'b10, A, D);
    // reset in the middle of an OWN0 sequence
    v[nv++] = mk(1, 1,0,1,32'h10,0, 0,0,0,32'h00,0, 2'b01,0,32'h10, 2'b00, A, D);
    v[nv++] = mk(1, 1,0,1,32'h40,0, 0,0,0,32'h00,0, 2'b01,0,32'h40, 2'b01, 5, D);
    v[nv++] = mk(0, 1,0,1,32'h40,0, 1,0,0,32'h20,0, 2'b00,0,32'h00, 2'b01, D, D);
    v[nv++] = mk(1, 0,0,0,32'h00,0, 1,0,0,32'h20,0, 2'b10,0,32'h20, 2'b00, 0, 0);
    v[nv++] = mk(1, 0,0,0,32'h00,0, 0,0,0,32'h00,0, 2'b00,0,32'h00, 2'b10, 0, A);

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      rst = v[i].rst;
      p0_req = v[i].r0; p0_we = v[i].w0; p0_lock = v[i].l0; p0_addr = v[i].a0; p0_wd = v[i].d0;
      p1_req = v[i].r1; p1_we = v[i].w1; p1_lock = v[i].l1; p1_addr = v[i].a1; p1_wd = v[i].d1;
      #1;
      chk($sformatf("row%0d gnt", i),    {30'd0, p1_gnt, p0_gnt},       {30'd0, v[i].gnt});
      chk($sformatf("row%0d mem_we", i), {31'd0, mem_we},               {31'd0, v[i].mwe});
      chk($sformatf("row%0d mem_a", i),  mem_a,                         v[i].ma);
      chk($sformatf("row%0d rvalid", i), {30'd0, p1_rvalid, p0_rvalid}, {30'd0, v[i].rv});
      chk($sformatf("row%0d p0_rdata", i), p0_rdata, v[i].rd0);
      chk($sformatf("row%0d p1_rdata", i), p1_rdata, v[i].rd1);
    end

    chk("rmw result at 0x10", mem[4], 32'd5);

    // p1 takes a locked write burst; p0 joins and must wait out exactly MAX_LOCK beats.
    p1_beats = 0;
    got0     = 1'b0;
    for (int c = 0; c < 20 && !got0; c++) begin
      @(negedge clk);
      p1_req = 1'b1; p1_we = 1'b1; p1_lock = 1'b1; p1_addr = 32'h30; p1_wd = 32'd100 + p1_beats;
      p0_req = (c > 0); p0_we = 1'b0; p0_lock = 1'b0; p0_addr = 32'h20; p0_wd = '0;
      #1;
      if (p0_gnt) got0 = 1'b1;
      if (p1_gnt) p1_beats++;
    end
    chk("burst p0 eventually granted", {31'd0, got0}, 32'd1);
    chk("burst p1 beats before release", p1_beats, 32'd4);

    @(negedge clk);
    {p0_req, p1_req, p0_lock, p1_lock, p1_we} = '0;
    #1;
    chk("burst p0 read returned", {31'd0, p0_rvalid}, 32'd1);
    chk("burst p0 read data", p0_rdata, A);
    chk("burst last write at 0x30", mem[12], 32'd103);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
